mouse_packet_decoder: RTL

Turns the byte stream from the PS/2 mouse receiver into the absolute cursor state used by the menu, mouse-overlay and game logic: `xpos`, `ypos` and the button levels. It reassembles standard 3-byte PS/2 movement packets and accumulates the signed deltas into screen coordinates clamped to the visible area. It sits between the PS/2 byte receiver and every consumer of `xpos`/`ypos`/`left`.

---
 rtl/mouse_pkg.sv | 35 +++
 rtl/mouse_packet_decoder_if.sv | 11 +
 rtl/mouse_axis_accum.sv | 33 +++
 rtl/mouse_packet_decoder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared PS/2 mouse constants, header layout and decoder state enum
package mouse_pkg;

    // Bit positions inside the first byte of a PS/2 movement packet.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Visible screen area, also used by the menu and overlay hit-box logic.
    localparam int SCREEN_XMAX   = 1023;
    localparam int SCREEN_YMAX   = 767;
    localparam int SCREEN_X_INIT = 512;
    localparam int SCREEN_Y_INIT = 384;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } mouse_state_e;

    // The parts of the first byte that matter once it has passed the sync check.
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic right;
        logic left;
    } mouse_hdr_t;

endpackage

// File: rtl/mouse_packet_decoder_if.sv
// rtl/mouse_packet_decoder_if.sv - byte stream from the PS/2 receiver into the decoder
// Signals:
//   rx_data  [7:0] received PS/2 byte
//   rx_valid       one-cycle strobe qualifying rx_data (no backpressure)
interface mouse_packet_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/mouse_axis_accum.sv
// rtl/mouse_axis_accum.sv - combinational position + signed delta with clamp to 0..max
// Ports:
//   pos   [11:0] current position
//   delta [9:0]  signed delta; one bit wider than a PS/2 delta so the negated
//                Y delta of -256 is still exactly +256
//   ovf          axis overflow flag, forces the delta to zero
//   max   [11:0] largest legal position
//   next  [11:0] clamped next position
module mouse_axis_accum (
    input  logic [11:0] pos,
    input  logic [9:0]  delta,
    input  logic        ovf,
    input  logic [11:0] max,
    output logic [11:0] next
);

    logic [13:0] d_ext;
    logic [13:0] sum;

    // 14 bits hold every pos+delta exactly: pos <= 4095 and |delta| <= 256.
    always_comb begin
        d_ext = ovf ? 14'd0 : {{4{delta[9]}}, delta};
        sum   = {2'b00, pos} + d_ext;
        if (sum[13]) begin
            next = 12'd0;
        end else if (sum[12:0] > {1'b0, max}) begin
            next = max;
        end else begin
            next = sum[11:0];
        end
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// rtl/mouse_packet_decoder.sv - PS/2 3-byte packet reassembly into clamped cursor position and buttons
// Ports:
//   clk        pixel clock
//   rst        asynchronous active-low reset
//   rx         byte stream (slave side of mouse_packet_decoder_if)
//   xpos/ypos  cursor position, 0..XMAX / 0..YMAX, 0 = top of screen
//   left/right button levels
//   pkt_valid  one-cycle pulse when a packet has been applied
//   sync_err   one-cycle pulse when a first byte without the sync bit is dropped
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int XMAX    = SCREEN_XMAX,
    parameter int YMAX    = SCREEN_YMAX,
    parameter int X_INIT  = SCREEN_X_INIT,
    parameter int Y_INIT  = SCREEN_Y_INIT,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    mouse_packet_decoder_if.slave        rx,
    output logic [11:0]                  xpos,
    output logic [11:0]                  ypos,
    output logic                         left,
    output logic                         right,
    output logic                         pkt_valid,
    output logic                         sync_err
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    mouse_state_e  state;
    mouse_state_e  eff_state;
    mouse_hdr_t    hdr;
    logic [7:0]    b1;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic [9:0]    dx;
    logic [9:0]    dy_neg;
    logic [11:0]   x_next;
    logic [11:0]   y_next;

    assign timeout = (state != WAIT_B0) && (cnt == CNT_MAX);

    // A byte landing in the cycle the timeout fires starts a fresh packet.
    assign eff_state = timeout ? WAIT_B0 : state;

    // The Y delta byte is only used in the cycle it arrives, so it feeds the
    // accumulator straight from the stream; Y is negated because PS/2 Y points up.
    assign dx     = {hdr.xsign, hdr.xsign, b1};
    assign dy_neg = 10'd0 - {hdr.ysign, hdr.ysign, rx.rx_data};

    mouse_axis_accum u_x_accum (
        .pos   (xpos),
        .delta (dx),
        .ovf   (hdr.xovf),
        .max   (12'(XMAX)),
        .next  (x_next)
    );

    mouse_axis_accum u_y_accum (
        .pos   (ypos),
        .delta (dy_neg),
        .ovf   (hdr.yovf),
        .max   (12'(YMAX)),
        .next  (y_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_B0;
            hdr       <= '0;
            b1        <= 8'd0;
            cnt       <= '0;
            xpos      <= 12'(X_INIT);
            ypos      <= 12'(Y_INIT);
            left      <= 1'b0;
            right     <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (rx.rx_valid) begin
                cnt <= '0;
                case (eff_state)
                    WAIT_B0: begin
                        if (!rx.rx_data[SYNC]) begin
                            sync_err <= 1'b1;
                            state    <= WAIT_B0;
                        end else begin
                            hdr   <= '{yovf:  rx.rx_data[YOVF],
                                       xovf:  rx.rx_data[XOVF],
                                       ysign: rx.rx_data[YSIGN],
                                       xsign: rx.rx_data[XSIGN],
                                       right: rx.rx_data[BTN_R],
                                       left:  rx.rx_data[BTN_L]};
                            state <= WAIT_B1;
                        end
                    end
                    WAIT_B1: begin
                        b1    <= rx.rx_data;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        xpos      <= x_next;
                        ypos      <= y_next;
                        left      <= hdr.left;
                        right     <= hdr.right;
                        pkt_valid <= 1'b1;
                        state     <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end else if (timeout) begin
                state <= WAIT_B0;
                cnt   <= '0;
            end else if (state != WAIT_B0 && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
